// File: rtl/unified_mem_ctrl.sv
// Shared I/D word memory with valid/ready requests and round-robin arbitration; MEM_BYTE_WRITE_EN adds d_be lane strobes.
// Accept to rvalid takes LATENCY cycles; one access in flight, so both readies stay low while busy.
module unified_mem_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 10,
  parameter int LATENCY    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [WIDTH-1:0]   i_addr,
  output logic               i_ready,
  output logic               i_rvalid,
  output logic [WIDTH-1:0]   i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [WIDTH-1:0]   d_addr,
  input  logic [WIDTH-1:0]   d_wdata,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [WIDTH/8-1:0] d_be,
`endif
  output logic               d_ready,
  output logic               d_rvalid,
  output logic [WIDTH-1:0]   d_rdata,
  output logic               busy
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  d_first_q, d_first_d;
  logic                  sel_d_q, sel_d_d;
  logic                  we_q, we_d;
  logic [DEPTH_BITS-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
`ifdef MEM_BYTE_WRITE_EN
  logic [WIDTH/8-1:0]    be_q, be_d;
`endif
  logic                  i_rvalid_q, i_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [WIDTH-1:0]      i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0]      d_rdata_q, d_rdata_d;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  grant_i, grant_d, mem_we;
  logic [WIDTH-1:0]      rd_word, wr_word;
  logic                  unused_addr_bits;

  // Addresses wrap modulo the array; byte offset and upper bits carry no meaning here.
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[WIDTH-1:DEPTH_BITS+2],
                              d_addr[1:0], d_addr[WIDTH-1:DEPTH_BITS+2]};

  // On contention the pointer decides; a lone requester always wins.
  assign grant_d = d_req && (!i_req || d_first_q);
  assign grant_i = i_req && (!d_req || !d_first_q);
  assign i_ready = (state_q == IDLE) && !grant_d;
  assign d_ready = (state_q == IDLE) && !grant_i;

  assign rd_word = mem[idx_q];

  always_comb begin
    wr_word = wdata_q;
`ifdef MEM_BYTE_WRITE_EN
    wr_word = rd_word;
    for (int b = 0; b < WIDTH/8; b++) begin
      if (be_q[b]) wr_word[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_first_d  = d_first_q;
    sel_d_d    = sel_d_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
`ifdef MEM_BYTE_WRITE_EN
    be_d       = be_q;
`endif
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = ACCESS;
          cnt_d     = 4'(LATENCY - 1);
          sel_d_d   = 1'b1;
          we_d      = d_we;
          idx_d     = d_addr[DEPTH_BITS+1:2];
          wdata_d   = d_wdata;
`ifdef MEM_BYTE_WRITE_EN
          be_d      = d_be;
`endif
          d_first_d = 1'b0;
        end else if (grant_i) begin
          state_d   = ACCESS;
          cnt_d     = 4'(LATENCY - 1);
          sel_d_d   = 1'b0;
          we_d      = 1'b0;
          idx_d     = i_addr[DEPTH_BITS+1:2];
          d_first_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (sel_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? wr_word : rd_word;
            mem_we     = we_q;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = rd_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      d_first_q  <= 1'b1;
      sel_d_q    <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
`ifdef MEM_BYTE_WRITE_EN
      be_q       <= '0;
`endif
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_first_q  <= d_first_d;
      sel_d_q    <= sel_d_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
`ifdef MEM_BYTE_WRITE_EN
      be_q       <= be_d;
`endif
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Array is never reset; a store completing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && reset) mem[idx_q] <= wr_word;
  end

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q == ACCESS);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: D-port vector table plus reset, fetch-stream and contention sequences.
module tb_unified_mem_ctrl;

  localparam int LAT = 2;
  localparam int DB  = 4;
`ifdef MEM_BYTE_WRITE_EN
  localparam bit BW = 1'b1;
`else
  localparam bit BW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ready, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_rvalid, busy;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be_s;

  unified_mem_ctrl #(.WIDTH(32), .DEPTH_BITS(DB), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef MEM_BYTE_WRITE_EN
    .d_be(d_be_s),
`endif
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .busy(busy)
  );

`ifndef MEM_BYTE_WRITE_EN
  logic unused_be;
  assign unused_be = ^d_be_s;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.exp = exp;
    vq.push_back(v);
  endtask

  // One D-port access: wait for ready, check busy, latency, data and a single-cycle strobe.
  task automatic d_access(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp);
    int k;
    int lat;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be_s = be;
    #1;
    k = 0;
    while (!d_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!d_ready) begin
      check({nm, "_ready_timeout"}, 32'(d_ready), 32'd1);
      d_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = ~we; d_addr = addr ^ 32'h3C; d_wdata = ~wdata; d_be_s = ~be;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    for (int j = 1; j <= LAT + 4; j++) begin
      @(posedge clk); #1;
      if (d_rvalid) begin
        lat = j;
        break;
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'(LAT));
    check({nm, "_rdata"}, d_rdata, exp);
    @(posedge clk); #1;
    check({nm, "_pulse"}, 32'(d_rvalid), 32'd0);
  endtask

  logic [31:0] faddr [3];
  logic [31:0] fexp  [3];
  int          acc_cyc [3];
  int          resp_cyc [3];
  int          gport [4];
  int          gcyc [4];

  initial begin
    int nacc, nresp, rdy_cnt, ng;
    bit acc_now, both, rv_seen;
    logic [3:0] ord;

    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be_s = 4'hF;

    add(1'b1, 32'h40,       32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    add(1'b0, 32'h40,       32'h0,        4'hF, 32'hDEADBEEF);
    add(1'b1, 32'h40,       32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5);
    add(1'b0, 32'h00,       32'h0,        4'hF, 32'hA5A5A5A5);
    add(1'b0, 32'h43,       32'h0,        4'hF, 32'hA5A5A5A5);
    add(1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF);
    add(1'b1, 32'h20,       32'h0000AB00, 4'h2, BW ? 32'hFFFFABFF : 32'h0000AB00);
    add(1'b0, 32'h20,       32'h0,        4'hF, BW ? 32'hFFFFABFF : 32'h0000AB00);
    add(1'b1, 32'h20,       32'h12345678, 4'h0, BW ? 32'hFFFFABFF : 32'h12345678);
    add(1'b0, 32'h21,       32'h0,        4'hF, BW ? 32'hFFFFABFF : 32'h12345678);
    add(1'b1, 32'h10,       32'hCAFEF00D, 4'hF, 32'hCAFEF00D);
    add(1'b1, 32'h00,       32'h00000013, 4'hF, 32'h00000013);
    add(1'b1, 32'h04,       32'h00100093, 4'hF, 32'h00100093);
    add(1'b1, 32'h08,       32'h00200113, 4'hF, 32'h00200113);
    add(1'b0, 32'h10000004, 32'h0,        4'hF, 32'h00100093);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_i_rdata",  i_rdata,       32'd0);
    check("rst_d_rdata",  d_rdata,       32'd0);
    check("rst_i_ready",  32'(i_ready),  32'd1);
    check("rst_d_ready",  32'(d_ready),  32'd1);
    reset = 1'b1;

    foreach (vq[i])
      d_access($sformatf("vec%0d", i), vq[i].we, vq[i].addr, vq[i].wdata, vq[i].be, vq[i].exp);

    // Store interrupted by reset must leave the word untouched and never ack.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678; d_be_s = 4'hF;
    #1;
    begin
      int k = 0;
      while (!d_ready && k < 20) begin @(posedge clk); #1; k++; end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    rv_seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; rv_seen |= d_rvalid; end
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_d_rdata",  d_rdata,   32'd0);
    check("mid_i_rdata",  i_rdata,   32'd0);
    reset = 1'b1;
    #1;
    check("mid_i_ready", 32'(i_ready), 32'd1);
    check("mid_d_ready", 32'(d_ready), 32'd1);
    repeat (LAT + 2) begin @(posedge clk); #1; rv_seen |= d_rvalid; end
    check("mid_no_rvalid", 32'(rv_seen), 32'd0);
    d_access("mid_reload", 1'b0, 32'h10, 32'h0, 4'hF, 32'hCAFEF00D);

    // Back-to-back fetch with i_req held.
    faddr[0] = 32'h0; faddr[1] = 32'h4; faddr[2] = 32'h8;
    fexp[0] = 32'h00000013; fexp[1] = 32'h00100093; fexp[2] = 32'h00200113;
    nacc = 0; nresp = 0; rdy_cnt = 0;
    i_req = 1'b1; i_addr = faddr[0];
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      #1;
      if (i_rvalid && nresp < 3) begin
        check($sformatf("fetch%0d_rdata", nresp), i_rdata, fexp[nresp]);
        resp_cyc[nresp] = c;
        nresp++;
      end
      acc_now = i_ready && i_req && (nacc < 3);
      if (i_req && i_ready) rdy_cnt++;
      if (acc_now) acc_cyc[nacc] = c;
      @(posedge clk); #1;
      if (acc_now) begin
        nacc++;
        if (nacc < 3) i_addr = faddr[nacc];
        else i_req = 1'b0;
      end
    end
    check("fetch_accepts",   32'(nacc),    32'd3);
    check("fetch_responses", 32'(nresp),   32'd3);
    check("fetch_ready_cyc", 32'(rdy_cnt), 32'd3);
    if (nacc == 3 && nresp == 3) begin
      check("fetch_gap01", 32'(acc_cyc[1] - acc_cyc[0]),  32'(LAT + 1));
      check("fetch_gap12", 32'(acc_cyc[2] - acc_cyc[1]),  32'(LAT + 1));
      check("fetch_lat2",  32'(resp_cyc[2] - acc_cyc[2]), 32'(LAT + 1));
    end
    repeat (2) @(posedge clk);
    #1;
    check("fetch_hold_rvalid", 32'(i_rvalid), 32'd0);
    check("fetch_hold_rdata",  i_rdata,       32'h00200113);

    // Contention from reset: D first, then alternation every LAT+1 cycles.
    reset = 1'b0; i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ng = 0; both = 1'b0;
    for (int k = 0; k < 4; k++) begin gport[k] = -1; gcyc[k] = 0; end
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if (i_ready && d_ready) both = 1'b1;
      if (d_ready) begin gport[ng] = 0; gcyc[ng] = c; ng++; end
      else if (i_ready) begin gport[ng] = 1; gcyc[ng] = c; ng++; end
      @(posedge clk);
    end
    #1;
    i_req = 1'b0; d_req = 1'b0;
    ord = '0;
    for (int k = 0; k < 4; k++) ord = {ord[2:0], gport[k] == 1};
    check("arb_grants",   32'(ng),   32'd4);
    check("arb_order",    32'(ord),  32'b0101);
    check("arb_one_ready", 32'(both), 32'd0);
    check("arb_gap_d", 32'(gcyc[2] - gcyc[0]), 32'(2 * (LAT + 1)));
    check("arb_gap_i", 32'(gcyc[3] - gcyc[1]), 32'(2 * (LAT + 1)));
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("arb_d_rdata", d_rdata, 32'h00200113);
    check("arb_i_rdata", i_rdata, 32'h00100093);
    check("arb_idle",    32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
